// File: rtl/uart_rcv_fifo_block.sv
// UART receiver with runtime parity/data-size selection and a frame FIFO.
// Define BREAK_DETECT_EN to add the sticky break_detect output.
module uart_rcv_fifo_block #(
    parameter int DATA_MAX   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BP_WIDTH   = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    input  logic [3:0]                    data_size,
    input  logic [BP_WIDTH-1:0]           bit_period,
    input  logic [1:0]                    parity_mode,
    input  logic                          data_read,
    input  logic                          err_clear,
    output logic [DATA_MAX-1:0]           rx_data,
    output logic                          data_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun_error,
    output logic                          framing_error,
`ifdef BREAK_DETECT_EN
    output logic                          break_detect,
`endif
    output logic                          parity_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, LOAD, WAIT_IDLE} state_t;

    state_t                             state_q, state_d;
    logic                               sync1_q, sync2_q, prev_q;
    logic [BP_WIDTH-1:0]                cnt_q, cnt_d, bp_q, bp_d;
    logic [3:0]                         dsize_q, dsize_d, bit_q, bit_d;
    logic                               par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic                               par_bit_q, par_bit_d, stop_q, stop_d;
    logic [DATA_MAX-1:0]                shift_q, shift_d;
    logic [FIFO_DEPTH-1:0][DATA_MAX-1:0] mem_q, mem_d;
    logic [AW-1:0]                      wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]                      count_q, count_d;
    logic                               oe_q, oe_d, fe_q, fe_d, pe_q, pe_d;
    logic                               pop, push, full_after_pop;
    logic                               oe_set, fe_set, pe_set;
`ifdef BREAK_DETECT_EN
    logic                               brk_q, brk_d, brk_set;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + BP_WIDTH'(1);
        bp_d      = bp_q;
        dsize_d   = dsize_q;
        bit_d     = bit_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bit_d = par_bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        push      = 1'b0;
        oe_set    = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
`ifdef BREAK_DETECT_EN
        brk_set   = 1'b0;
`endif
        pop            = data_read && (count_q != '0);
        full_after_pop = (count_q == CW'(FIFO_DEPTH)) && !pop;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d   = START;
                    bp_d      = (bit_period < BP_WIDTH'(4)) ? BP_WIDTH'(4) : bit_period;
                    if (data_size < 4'd5)                 dsize_d = 4'd5;
                    else if (int'(data_size) > DATA_MAX)  dsize_d = 4'(DATA_MAX);
                    else                                  dsize_d = data_size;
                    par_en_d  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                    par_odd_d = (parity_mode == 2'd2);
                    par_bit_d = 1'b0;
                    bit_d     = '0;
                    shift_d   = '0;
                end
            end
            // The edge reaches this FSM two clocks late through the synchronizer,
            // so the start sample is taken early by the same amount to stay mid-bit.
            START: begin
                if (cnt_q == (bp_q >> 1) - BP_WIDTH'(2)) begin
                    cnt_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == bp_q - BP_WIDTH'(1)) begin
                    cnt_d   = '0;
                    shift_d = shift_q | (DATA_MAX'(sync2_q) << bit_q);
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == dsize_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt_q == bp_q - BP_WIDTH'(1)) begin
                    cnt_d     = '0;
                    par_bit_d = sync2_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_q == bp_q - BP_WIDTH'(1)) begin
                    stop_d  = sync2_q;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = IDLE;
                if (!stop_q) begin
                    fe_set  = 1'b1;
                    state_d = WAIT_IDLE;
`ifdef BREAK_DETECT_EN
                    brk_set = (shift_q == '0) && !(par_en_q && par_bit_q);
`endif
                end else if (par_en_q && (par_bit_q != ((^shift_q) ^ par_odd_q))) begin
                    pe_set = 1'b1;
                end else if (full_after_pop) begin
                    oe_set = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            WAIT_IDLE: if (sync2_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        mem_d = mem_q;
        if (push) mem_d[wr_q] = shift_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop  ? rd_q + AW'(1) : rd_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // A flag raised in the same cycle as err_clear stays set.
        oe_d  = (oe_q & ~err_clear) | oe_set;
        fe_d  = (fe_q & ~err_clear) | fe_set;
        pe_d  = (pe_q & ~err_clear) | pe_set;
`ifdef BREAK_DETECT_EN
        brk_d = (brk_q & ~err_clear) | brk_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bp_q      <= BP_WIDTH'(4);
            dsize_q   <= 4'd5;
            bit_q     <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= 1'b1;
            shift_q   <= '0;
            mem_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            oe_q      <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
`ifdef BREAK_DETECT_EN
            brk_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= serial_in;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            cnt_q     <= cnt_d;
            bp_q      <= bp_d;
            dsize_q   <= dsize_d;
            bit_q     <= bit_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bit_q <= par_bit_d;
            stop_q    <= stop_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            oe_q      <= oe_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
`ifdef BREAK_DETECT_EN
            brk_q     <= brk_d;
`endif
        end
    end

    assign data_ready    = (count_q != '0);
    assign rx_data       = data_ready ? mem_q[rd_q] : '0;
    assign fifo_count    = count_q;
    assign overrun_error = oe_q;
    assign framing_error = fe_q;
    assign parity_error  = pe_q;
`ifdef BREAK_DETECT_EN
    assign break_detect  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rcv_fifo_block.sv
// Scoreboard bench for uart_rcv_fifo_block: a serial driver plus a queue/flag model
// of the receiver; a monitor checks every popped frame against the model queue.
module tb_uart_rcv_fifo_block;
    localparam int DATA_MAX   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int BP_WIDTH   = 14;
    localparam int CLK_HALF   = 5;   // time unit = 0.25 ns, so clk = 2.5 ns

    logic                clk = 1'b0;
    logic                rst, serial_in, data_read, err_clear;
    logic [3:0]          data_size;
    logic [BP_WIDTH-1:0] bit_period;
    logic [1:0]          parity_mode;
    logic [DATA_MAX-1:0] rx_data;
    logic                data_ready, overrun_error, framing_error, parity_error;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef BREAK_DETECT_EN
    logic                break_detect;
`endif

    uart_rcv_fifo_block #(.DATA_MAX(DATA_MAX), .FIFO_DEPTH(FIFO_DEPTH), .BP_WIDTH(BP_WIDTH)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .data_size(data_size),
        .bit_period(bit_period), .parity_mode(parity_mode), .data_read(data_read),
        .err_clear(err_clear), .rx_data(rx_data), .data_ready(data_ready),
        .fifo_count(fifo_count), .overrun_error(overrun_error), .framing_error(framing_error),
`ifdef BREAK_DETECT_EN
        .break_detect(break_detect),
`endif
        .parity_error(parity_error)
    );

    always #CLK_HALF clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];
    bit m_oe, m_fe, m_pe, m_brk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Data_read is driven just after a posedge, so this negedge sees the head about to pop.
    always @(negedge clk) begin
        if (!rst && data_read && data_ready) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", longint'(rx_data), longint'(exp_q.pop_front()));
        end
    end

    task automatic clear_model_flags();
        m_oe = 0; m_fe = 0; m_pe = 0; m_brk = 0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, ":fifo_count"}, longint'(fifo_count), longint'(exp_q.size()));
        chk({tag, ":data_ready"}, longint'(data_ready), longint'(exp_q.size() != 0));
        chk({tag, ":rx_data"}, longint'(rx_data), (exp_q.size() != 0) ? longint'(exp_q[0]) : 0);
        chk({tag, ":overrun"}, longint'(overrun_error), longint'(m_oe));
        chk({tag, ":framing"}, longint'(framing_error), longint'(m_fe));
        chk({tag, ":parity"}, longint'(parity_error), longint'(m_pe));
`ifdef BREAK_DETECT_EN
        chk({tag, ":break"}, longint'(break_detect), longint'(m_brk));
`endif
    endtask

    task automatic pop_one();
        @(posedge clk); #1 data_read = 1'b1;
        @(posedge clk); #1 data_read = 1'b0;
    endtask

    task automatic clear_errors();
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        clear_model_flags();
    endtask

    // pulse: 0 none, 1 data_read, 2 err_clear, aimed at the frame's load clock.
    task automatic send_frame(input logic [7:0] d, input int ds, input int pm, input bit bad_par,
                              input bit bad_stop, input int bp, input int pulse, input int low_extra);
        logic [8:0] mask = (9'd1 << ds) - 9'd1;
        logic [7:0] dm   = d & mask[7:0];
        bit   par_en     = (pm == 1) || (pm == 2);
        logic pbit       = (^dm) ^ (pm == 2) ^ bad_par;
        int   bit_u      = bp * 10;
        int   nb         = ds + (par_en ? 1 : 0) + 1;
        int   load_t     = 25 + ((bp / 2) - 1) * 10 + bit_u * nb + 10;
        @(negedge clk);
        data_size = 4'(ds); bit_period = BP_WIDTH'(bp); parity_mode = 2'(pm);
        @(negedge clk);
        serial_in = 1'b0;
        if (pulse != 0) begin
            fork
                begin
                    #(load_t - 9);
                    if (pulse == 1) data_read = 1'b1; else err_clear = 1'b1;
                    #10;
                    data_read = 1'b0; err_clear = 1'b0;
                end
            join_none
        end
        #(bit_u / 2);
        data_size = 4'($urandom_range(0, 15)); parity_mode = 2'($urandom_range(0, 3));
        bit_period = BP_WIDTH'($urandom_range(0, 40));
        #(bit_u - bit_u / 2);
        for (int i = 0; i < ds; i++) begin serial_in = dm[i]; #(bit_u); end
        if (par_en) begin serial_in = pbit; #(bit_u); end
        serial_in = !bad_stop;
        #(bit_u);
        if (low_extra > 0) begin
            #(low_extra * bit_u);
            chk("no_false_frame_while_low", longint'(fifo_count), longint'(exp_q.size()));
        end
        serial_in = 1'b1;
        #(2 * bit_u);
        if (pulse == 2) clear_model_flags();
        if (bad_stop) begin
            m_fe = 1;
            if (dm == 0 && !(par_en && pbit)) m_brk = 1;
        end else if (par_en && bad_par) m_pe = 1;
        else if (exp_q.size() == FIFO_DEPTH) m_oe = 1;
        else exp_q.push_back(dm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; serial_in = 1'b1; data_read = 1'b0; err_clear = 1'b0;
        data_size = 4'd8; bit_period = BP_WIDTH'(10); parity_mode = 2'd0;
        clear_model_flags();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_state("reset");

        send_frame(8'h81, 8, 0, 0, 0, 10, 0, 0);
        check_state("t1_rx");
        pop_one();
        check_state("t1_pop");

        send_frame(8'h55, 7, 1, 0, 0, 10, 0, 0);
        send_frame(8'h55, 7, 1, 1, 0, 10, 0, 0);
        check_state("t2_parity");
        send_frame(8'h3A, 8, 2, 0, 0, 10, 0, 0);
        send_frame(8'h17, 6, 3, 0, 0, 10, 0, 0);
        check_state("t2_odd_none");
        clear_errors();
        repeat (3) pop_one();
        check_state("t2_drained");

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 0, 0, 10, 0, 0);
        check_state("t3_overrun");
        repeat (4) pop_one();
        pop_one();
        check_state("t3_empty_pop");
        clear_errors();

        send_frame(8'h7E, 8, 0, 0, 1, 10, 0, 2);
        check_state("t4_framing");
        clear_errors();
        check_state("t4_cleared");

        send_frame(8'hA9, 8, 0, 0, 0, 10, 0, 0);
        exp_q.delete(); exp_q.push_back(8'hA9);
        pop_one();
        check_state("t5_nominal");
        begin
            // Same frames but the driver runs 4% slow / fast against bit_period=10.
            int saved;
            saved = 0;
            @(negedge clk);
            data_size = 4'd8; bit_period = BP_WIDTH'(10); parity_mode = 2'd0;
            @(negedge clk);
            serial_in = 1'b0; #104;
            for (int i = 0; i < 8; i++) begin serial_in = 8'hA9 >> i; #104; end
            serial_in = 1'b1; #208;
            serial_in = 1'b0; #96;
            for (int i = 0; i < 8; i++) begin serial_in = 8'h81 >> i; #96; end
            serial_in = 1'b1; #192;
            exp_q.push_back(8'hA9); exp_q.push_back(8'h81);
            saved = exp_q.size();
            chk("t5_skew_count", longint'(fifo_count), longint'(saved));
        end
        check_state("t5_skew");
        repeat (2) pop_one();

        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 8, 0, 0, 0, 10, 0, 0);
        send_frame(8'hC3, 8, 0, 0, 0, 10, 1, 0);
        check_state("push_pop_full");
        repeat (4) pop_one();

        send_frame(8'h00, 8, 0, 0, 1, 10, 0, 0);
        check_state("break_pattern");
        send_frame(8'h6D, 8, 1, 1, 0, 10, 2, 0);
        check_state("clear_vs_new_error");
        clear_errors();

        send_frame(8'h11, 8, 0, 0, 0, 10, 0, 0);
        send_frame(8'h22, 8, 1, 1, 0, 10, 0, 0);
        @(negedge clk);
        data_size = 4'd8; bit_period = BP_WIDTH'(10); parity_mode = 2'd0;
        @(negedge clk);
        serial_in = 1'b0; #100;
        for (int i = 0; i < 4; i++) begin serial_in = 8'h96 >> i; #100; end
        #50;
        rst = 1'b1; serial_in = 1'b1;
        @(posedge clk); @(negedge clk);
        exp_q.delete(); clear_model_flags();
        check_state("t6_reset_mid");
        rst = 1'b0;
        #400;
        send_frame(8'h3C, 8, 0, 0, 0, 10, 0, 0);
        check_state("t6_after");
        pop_one();

        for (int n = 0; n < 20; n++) begin
            int ds = $urandom_range(5, 8);
            int pm = $urandom_range(0, 3);
            bit pe = ((pm == 1) || (pm == 2)) && ($urandom_range(0, 5) == 0);
            bit se = ($urandom_range(0, 7) == 0);
            int bp = ($urandom_range(0, 1) == 0) ? 10 : 12;
            send_frame(8'($urandom), ds, pm, pe, se, bp, 0, 0);
            check_state("rand");
            if ($urandom_range(0, 1) == 1) pop_one();
            if ($urandom_range(0, 4) == 0) clear_errors();
        end
        while (exp_q.size() != 0 && checks < 100000) pop_one();
        check_state("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
